// File: rtl/port_out_fifo.sv
// rtl/port_out_fifo.sv - CPU output-port FIFO drained over valid/ready; status port via PORT_FIFO_STATUS_EN
// PORT_FIFO_STATUS_EN: enables the status read at STATUS_PORT and read-to-clear of overflow.
module port_out_fifo #(
   parameter int WORD_SIZE   = 16,
   parameter int DEPTH       = 8,
   parameter int DATA_PORT   = 1,
   parameter int STATUS_PORT = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WORD_SIZE-1:0] portaddr,
   input  logic [WORD_SIZE-1:0] portval,
   input  logic                 get_enable,
   input  logic                 set_enable,
   output logic [WORD_SIZE-1:0] portout,
   output logic                 busy,
   output logic                 overflow,
   output logic [WORD_SIZE-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]          CNT_FULL    = (AW+1)'(DEPTH);
   localparam logic [AW:0]          CNT_ONE     = (AW+1)'(1);
   localparam logic [AW-1:0]        PTR_ONE     = AW'(1);
   localparam logic [WORD_SIZE-1:0] DATA_ADDR   = WORD_SIZE'(DATA_PORT);
   localparam logic [WORD_SIZE-1:0] STATUS_ADDR = WORD_SIZE'(STATUS_PORT);

   logic [WORD_SIZE-1:0] mem [DEPTH];
   logic [AW-1:0]        rd_ptr, wr_ptr;
   logic [AW:0]          count;
   logic                 full, empty, pop, wr_req, push, drop;

   assign full      = (count == CNT_FULL);
   assign empty     = (count == '0);
   assign busy      = full;
   assign out_valid = !empty;
   assign out_data  = mem[rd_ptr];

   // A pop in the same cycle frees the slot, so a write to a full FIFO is still accepted.
   assign pop    = out_valid && out_ready;
   assign wr_req = set_enable && !get_enable && (portaddr == DATA_ADDR);
   assign push   = wr_req && (!full || pop);
   assign drop   = wr_req && full && !pop;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= portval;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

`ifdef PORT_FIFO_STATUS_EN
   logic                 status_rd;
   logic [WORD_SIZE-1:0] status_word;
   logic [WORD_SIZE-1:0] portout_q;

   assign status_rd = get_enable && (portaddr == STATUS_ADDR);

   always_comb begin
      status_word              = '0;
      status_word[AW:0]        = count;
      status_word[WORD_SIZE-1] = overflow;
      status_word[WORD_SIZE-2] = full;
      status_word[WORD_SIZE-3] = empty;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         portout_q <= '0;
      end else begin
         if (drop)           overflow <= 1'b1;
         else if (status_rd) overflow <= 1'b0;
         if (get_enable) portout_q <= status_rd ? status_word : '0;
      end
   end

   assign portout = portout_q;
`else
   logic unused_status_addr;
   assign unused_status_addr = ^STATUS_ADDR;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
   end

   assign portout = '0;
`endif
endmodule

// File: tb/tb_port_out_fifo.sv
// tb/tb_port_out_fifo.sv - scoreboard bench for port_out_fifo
module tb_port_out_fifo;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] portaddr = '0;
   logic [15:0] portval = '0;
   logic        get_enable = 1'b0;
   logic        set_enable = 1'b0;
   logic [15:0] portout;
   logic        busy;
   logic        overflow;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;

   port_out_fifo #(.WORD_SIZE(16), .DEPTH(DEPTH), .DATA_PORT(1), .STATUS_PORT(2)) dut (
      .clk(clk), .rst_n(rst_n), .portaddr(portaddr), .portval(portval),
      .get_enable(get_enable), .set_enable(set_enable), .portout(portout),
      .busy(busy), .overflow(overflow), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [15:0] exp_q[$];
   int          m_cnt = 0;
   logic        m_ovf = 1'b0;
   logic [15:0] m_portout = '0;
   logic        pop_m, wr_m;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: FIFO occupancy as an integer, accepted words in exp_q.
   always @(posedge clk) begin
      if (rst_n) begin
         pop_m = (m_cnt != 0) && out_ready;
         wr_m  = set_enable && !get_enable && (portaddr == 16'd1);
`ifdef PORT_FIFO_STATUS_EN
         if (get_enable) begin
            if (portaddr == 16'd2) begin
               m_portout = 16'(m_cnt);
               if (m_ovf)          m_portout[15] = 1'b1;
               if (m_cnt == DEPTH) m_portout[14] = 1'b1;
               if (m_cnt == 0)     m_portout[13] = 1'b1;
               m_ovf = 1'b0;
            end else begin
               m_portout = 16'h0000;
            end
         end
`endif
         if (wr_m) begin
            if (m_cnt < DEPTH || pop_m) begin
               exp_q.push_back(portval);
               m_cnt++;
            end else begin
               m_ovf = 1'b1;
            end
         end
         if (pop_m) m_cnt--;
      end
   end

   // Monitor: compares status outputs every cycle and each drained word at handshake.
   always @(negedge clk) begin
      chk("out_valid", 16'(out_valid), 16'(m_cnt != 0));
      chk("busy", 16'(busy), 16'(m_cnt == DEPTH));
      chk("overflow", 16'(overflow), 16'(m_ovf));
      chk("portout", portout, m_portout);
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_extra: got %h expected no word", out_data);
         end else begin
            chk("out_data", out_data, exp_q.pop_front());
         end
      end
   end

   task automatic cyc(input logic se, input logic ge, input logic [15:0] a,
                      input logic [15:0] v, input logic rdy);
      set_enable = se;
      get_enable = ge;
      portaddr   = a;
      portval    = v;
      out_ready  = rdy;
      @(posedge clk);
      #1;
      set_enable = 1'b0;
      get_enable = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH + 4; i++) cyc(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
      chk("drained_all", 16'(exp_q.size()), 16'd0);
   endtask

   initial begin
      #12 rst_n = 1'b1;
      @(posedge clk);
      #1;
      // three words, status, drain
      for (int i = 5; i <= 7; i++) cyc(1'b1, 1'b0, 16'd1, 16'(i), 1'b0);
      cyc(1'b0, 1'b1, 16'd2, 16'h0, 1'b0);
      drain();
      // overfill, two status reads
      for (int i = 1; i <= 9; i++) cyc(1'b1, 1'b0, 16'd1, 16'(i), 1'b0);
      cyc(1'b0, 1'b1, 16'd2, 16'h0, 1'b0);
      cyc(1'b0, 1'b1, 16'd2, 16'h0, 1'b0);
      // write to full FIFO with simultaneous pop
      cyc(1'b1, 1'b0, 16'd1, 16'h00AA, 1'b1);
      drain();
      // pointer wrap with continuous drain
      for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 16'd1, 16'($urandom), 1'b1);
      drain();
      // random traffic
      for (int i = 0; i < 400; i++)
         cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
             16'($urandom_range(0, 3)), 16'($urandom), 1'($urandom_range(0, 2) == 0));
      drain();
      // overflow then reset mid-cycle with entries queued
      for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 16'd1, 16'(100 + i), 1'b0);
      drain();
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 16'd1, 16'(200 + i), 1'b0);
      rst_n = 1'b0;
      #1;
      chk("rst_out_valid", 16'(out_valid), 16'd0);
      chk("rst_busy", 16'(busy), 16'd0);
      chk("rst_overflow", 16'(overflow), 16'd0);
      chk("rst_portout", portout, 16'd0);
      m_cnt = 0;
      m_ovf = 1'b0;
      m_portout = '0;
      exp_q.delete();
      #2 rst_n = 1'b1;
      cyc(1'b1, 1'b0, 16'd1, 16'h1234, 1'b0);
      cyc(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      drain();
      // non-data accesses
      cyc(1'b1, 1'b0, 16'd1, 16'h0033, 1'b0);
      cyc(1'b0, 1'b1, 16'd1, 16'h0, 1'b0);
      cyc(1'b1, 1'b0, 16'd2, 16'h0055, 1'b0);
      cyc(1'b0, 1'b1, 16'd2, 16'h0, 1'b0);
      cyc(1'b1, 1'b1, 16'd1, 16'h0077, 1'b0);
      drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
